pixel_deserializer: RTL and testbench

PIXEL_DESERIALIZER -- requirements
Module: pixel_deserializer

---
 rtl/pixel_pkg.sv | 10 +
 rtl/pix_hold_reg.sv | 62 ++++++
 rtl/pixel_deserializer.sv | 82 ++++++++
 tb/tb_pixel_deserializer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel constants and channel-order encoding for the deserializer slice.
package pixel_pkg;
  localparam int DEF_CH_W = 8;
  localparam int DEF_N_CH = 3;

  typedef enum logic {
    ORDER_NAT = 1'b0,
    ORDER_REV = 1'b1
  } order_e;
endpackage

// File: rtl/pix_hold_reg.sv
// Valid/ready output holding register: loads completed pixels, tracks drops and load count.
module pix_hold_reg #(
  parameter int PIX_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req_i,
  input  logic [PIX_W-1:0] din_i,
  input  logic             out_ready_i,
  input  logic             ovf_clr_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, drop;

  // A held pixel may be consumed and replaced on the same edge.
  assign load = load_req_i && (!vld_q || out_ready_i);
  assign drop = load_req_i && vld_q && !out_ready_i;

  always_comb begin
    pix_d = pix_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (load) begin
      pix_d = din_i;
      vld_d = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (vld_q && out_ready_i) begin
      vld_d = 1'b0;
    end
    // A fresh drop wins over a simultaneous clear.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pix_q <= pix_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign pix_o   = pix_q;
  assign valid_o = vld_q;
  assign ovf_o   = ovf_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/pixel_deserializer.sv
// Serial-to-parallel pixel assembler with optional channel reversal and a
// valid/ready output register that flags dropped pixels.
module pixel_deserializer
  import pixel_pkg::*;
#(
  parameter int CH_W      = DEF_CH_W,
  parameter int N_CH      = DEF_N_CH,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_in,
  input  logic                 input_valid,
  input  logic                 order_rev,
  input  logic                 out_ready,
  input  logic                 ovf_clr,
  output logic [CH_W*N_CH-1:0] pix,
  output logic                 output_valid,
  output logic                 overflow,
  output logic [CNT_W-1:0]     pix_cnt
);
  localparam int PIX_W = CH_W * N_CH;
  localparam int BC_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam logic [BC_W-1:0] LAST = BC_W'(PIX_W - 1);

  logic [PIX_W-1:0] sreg_q, sreg_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [PIX_W-1:0] word, ordered;
  logic             done, rev;

  // The completing word includes the bit presented on this edge.
  always_comb begin
    if (MSB_FIRST != 0) word = {sreg_q[PIX_W-2:0], shift_in};
    else                word = {shift_in, sreg_q[PIX_W-1:1]};
  end

  assign done = input_valid && (bcnt_q == LAST);

  // A gap in input_valid abandons the partial word.
  always_comb begin
    sreg_d = '0;
    bcnt_d = '0;
    if (input_valid) begin
      sreg_d = word;
      bcnt_d = done ? '0 : bcnt_q + BC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      bcnt_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign rev = (order_e'(order_rev) == ORDER_REV);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ordered[k*CH_W +: CH_W] = rev ? word[(N_CH-1-k)*CH_W +: CH_W]
                                         : word[k*CH_W +: CH_W];
  end

  pix_hold_reg #(
    .PIX_W (PIX_W),
    .CNT_W (CNT_W)
  ) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_req_i  (done),
    .din_i       (ordered),
    .out_ready_i (out_ready),
    .ovf_clr_i   (ovf_clr),
    .pix_o       (pix),
    .valid_o     (output_valid),
    .ovf_o       (overflow),
    .cnt_o       (pix_cnt)
  );
endmodule

// File: tb/tb_pixel_deserializer.sv
// Directed bench: default 24-bit RGB instance plus a 4x10-bit LSB-first instance.
module tb_pixel_deserializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        shift_in = 1'b0, input_valid = 1'b0, order_rev = 1'b0;
  logic        out_ready = 1'b1, ovf_clr = 1'b0;
  logic [23:0] pix;
  logic        output_valid, overflow;
  logic [15:0] pix_cnt;

  logic        shift_in_b = 1'b0, input_valid_b = 1'b0;
  logic [39:0] pix_b;
  logic        output_valid_b, overflow_b;
  logic [15:0] pix_cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pixel_deserializer u_dut (
    .clk(clk), .rst_n(rst_n), .shift_in(shift_in), .input_valid(input_valid),
    .order_rev(order_rev), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .pix(pix), .output_valid(output_valid), .overflow(overflow), .pix_cnt(pix_cnt)
  );

  pixel_deserializer #(.CH_W(10), .N_CH(4), .MSB_FIRST(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .shift_in(shift_in_b), .input_valid(input_valid_b),
    .order_rev(1'b0), .out_ready(1'b1), .ovf_clr(1'b0),
    .pix(pix_b), .output_valid(output_valid_b), .overflow(overflow_b), .pix_cnt(pix_cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // MSB-first send of the first nb bits of w; quiet checks no early output_valid.
  task automatic send_a(input logic [23:0] w, input int nb, input bit quiet);
    for (int i = 0; i < nb; i++) begin
      shift_in = w[23-i];
      input_valid = 1'b1;
      tick();
      if (quiet && i < 23) chk("quiet", output_valid, 1'b0);
    end
    input_valid = 1'b0;
    shift_in = 1'b0;
  endtask

  logic [39:0] wb [2];

  initial begin
    wb[0] = {10'h3FF, 10'h0F0, 10'h1C3, 10'h2A5};
    wb[1] = {10'h001, 10'h200, 10'h155, 10'h0AA};

    // Reset state
    repeat (2) tick();
    chk("rst_pix", pix, 24'h0);
    chk("rst_vld", output_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_cnt", pix_cnt, 16'h0);
    rst_n = 1'b1;
    tick();

    // Natural order, single-cycle valid pulse
    out_ready = 1'b1; order_rev = 1'b0;
    send_a(24'hFF8001, 24, 1'b1);
    chk("nat_vld", output_valid, 1'b1);
    chk("nat_pix", pix, 24'hFF8001);
    chk("nat_cnt", pix_cnt, 16'd1);
    tick();
    chk("nat_vld_drop", output_valid, 1'b0);

    // Reversed order
    do_reset();
    order_rev = 1'b1;
    send_a(24'hFF8001, 24, 1'b1);
    order_rev = 1'b0;
    chk("rev_vld", output_valid, 1'b1);
    chk("rev_pix", pix, 24'h0180FF);
    chk("rev_cnt", pix_cnt, 16'd1);
    tick();

    // Partial word abandoned by an input_valid gap
    do_reset();
    send_a(24'hABCDEF, 10, 1'b1);
    tick();
    chk("gap_vld", output_valid, 1'b0);
    send_a(24'h123456, 24, 1'b1);
    chk("gap_vld2", output_valid, 1'b1);
    chk("gap_pix", pix, 24'h123456);
    chk("gap_cnt", pix_cnt, 16'd1);
    tick();

    // Backpressure, overflow and clear
    do_reset();
    out_ready = 1'b0;
    send_a(24'hAAAAAA, 24, 1'b1);
    chk("bp_pix1", pix, 24'hAAAAAA);
    chk("bp_ovf1", overflow, 1'b0);
    send_a(24'h555555, 24, 1'b0);
    chk("bp_pix2", pix, 24'hAAAAAA);
    chk("bp_vld2", output_valid, 1'b1);
    chk("bp_ovf2", overflow, 1'b1);
    chk("bp_cnt2", pix_cnt, 16'd1);
    ovf_clr = 1'b1;
    tick();
    chk("bp_clr", overflow, 1'b0);
    send_a(24'h555555, 24, 1'b0);
    chk("bp_clr_vs_set", overflow, 1'b1);
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_consumed", output_valid, 1'b0);
    chk("bp_cnt3", pix_cnt, 16'd1);
    chk("bp_pix3", pix, 24'hAAAAAA);

    // Reset mid-word
    do_reset();
    out_ready = 1'b0;
    send_a(24'hABCDEF, 24, 1'b1);
    send_a(24'h654321, 12, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pix", pix, 24'h0);
    chk("mid_rst_vld", output_valid, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_cnt", pix_cnt, 16'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_a(24'h00000F, 24, 1'b1);
    chk("mid_rst_pix2", pix, 24'h00000F);
    chk("mid_rst_cnt2", pix_cnt, 16'd1);
    tick();

    // Wide instance, LSB first, back-to-back words
    do_reset();
    for (int i = 0; i < 80; i++) begin
      shift_in_b = wb[i/40][i%40];
      input_valid_b = 1'b1;
      tick();
      if (i % 40 == 39) begin
        chk("b_vld", output_valid_b, 1'b1);
        chk("b_pix", pix_b, wb[i/40]);
        chk("b_cnt", pix_cnt_b, 16'((i/40) + 1));
      end else if (i % 10 == 5) begin
        chk("b_quiet", output_valid_b, 1'b0);
      end
    end
    input_valid_b = 1'b0;
    chk("b_ch0", pix_b[9:0], 10'h0AA);
    tick();
    chk("b_vld_drop", output_valid_b, 1'b0);
    chk("b_ovf", overflow_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
